// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MMU and the RAM/IO bus: latch, translate, access, complete.
// Optional bus-ack timeout is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        req,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_valid,
    output logic [2:0]  exc_code,
    output logic        mmu_addrValid,
    output logic [1:0]  mmu_accessType,
    input  logic [31:0] mmu_pAddr,
    input  logic        mmu_io,
    input  logic [1:0]  mmu_exc,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic        ram_cs,
    output logic        io_cs,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XLATE  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] EXC_ADEL   = 3'd4;
    localparam logic [2:0] EXC_ADES   = 3'd5;
    localparam logic [2:0] EXC_BUSERR = 3'd6;

    if (CNT_WIDTH < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_check
        $error("CNT_WIDTH too small for TIMEOUT_CYCLES");
    end

    state_t      state_q, state_d;

    logic        wr_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] wdata_q;

    logic [1:0]  off_q, off_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        bus_we_q, bus_we_d;
    logic        ram_cs_q, ram_cs_d;
    logic        io_cs_q, io_cs_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  exc_code_q, exc_code_d;
    logic        fault_q, fault_d;

    logic        misaligned;
    logic        xlate_fault;
    logic [2:0]  xlate_code;
    logic        timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    lane_be = 4'b0001 << off;
            2'd1:    lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'd0:    lane_wdata = {4{wd[7:0]}};
            2'd1:    lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] sz, input logic sg,
                                            input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (sz)
            2'd0:    extract = sg ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            2'd1:    extract = sg ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            default: extract = rd;
        endcase
    endfunction

    // Size 3 is handled as a word everywhere via size[1].
    assign misaligned  = ((size_q == 2'd1) && mmu_pAddr[0]) ||
                         (size_q[1] && (mmu_pAddr[1:0] != 2'b00));
    assign xlate_fault = (mmu_exc != 2'd0) || misaligned;
    assign xlate_code  = (mmu_exc != 2'd0) ? {1'b0, mmu_exc} :
                         (wr_q ? EXC_ADES : EXC_ADEL);

`ifdef MEM_ACCESS_TIMEOUT_EN
    assign timeout = !bus_ack && ((cnt_q + 1'b1) == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req) state_d = S_XLATE;
            S_XLATE:  state_d = xlate_fault ? S_DONE : S_ACCESS;
            S_ACCESS: if (bus_ack || timeout) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        exc_valid      = (state_q == S_DONE) && fault_q;
        mmu_addrValid  = (state_q == S_IDLE) && req;
        mmu_accessType = (state_q == S_IDLE) ? {1'b0, req_write} : 2'd0;

        off_d       = off_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_we_d    = bus_we_q;
        ram_cs_d    = ram_cs_q;
        io_cs_d     = io_cs_q;
        rdata_d     = rdata_q;
        exc_code_d  = exc_code_q;
        fault_d     = fault_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rdata_d    = 32'd0;
                    exc_code_d = 3'd0;
                    fault_d    = 1'b0;
                end
            end
            S_XLATE: begin
                off_d = mmu_pAddr[1:0];
`ifdef MEM_ACCESS_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (xlate_fault) begin
                    fault_d    = 1'b1;
                    exc_code_d = xlate_code;
                end else begin
                    bus_addr_d  = {mmu_pAddr[31:2], 2'b00};
                    bus_wdata_d = lane_wdata(size_q, wdata_q);
                    bus_be_d    = lane_be(size_q, mmu_pAddr[1:0]);
                    bus_we_d    = wr_q;
                    io_cs_d     = mmu_io;
                    ram_cs_d    = !mmu_io;
                end
            end
            S_ACCESS: begin
                if (bus_ack || timeout) begin
                    ram_cs_d = 1'b0;
                    io_cs_d  = 1'b0;
                    bus_we_d = 1'b0;
                    bus_be_d = 4'd0;
                end
                if (bus_ack) begin
                    rdata_d = wr_q ? 32'd0 : extract(size_q, sgn_q, off_q, bus_rdata);
                end else if (timeout) begin
                    rdata_d    = 32'd0;
                    fault_d    = 1'b1;
                    exc_code_d = EXC_BUSERR;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                if (!bus_ack) cnt_d = cnt_q + 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Request fields only matter after acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && req) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            off_q       <= 2'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_we_q    <= 1'b0;
            ram_cs_q    <= 1'b0;
            io_cs_q     <= 1'b0;
            rdata_q     <= 32'd0;
            exc_code_q  <= 3'd0;
            fault_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            off_q       <= off_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_we_q    <= bus_we_d;
            ram_cs_q    <= ram_cs_d;
            io_cs_q     <= io_cs_d;
            rdata_q     <= rdata_d;
            exc_code_q  <= exc_code_d;
            fault_q     <= fault_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign bus_we    = bus_we_q;
    assign ram_cs    = ram_cs_q;
    assign io_cs     = io_cs_q;
    assign rdata     = rdata_q;
    assign exc_code  = exc_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; covers the timeout path when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        req = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy, done, exc_valid, mmu_addrValid;
    logic [31:0] rdata;
    logic [2:0]  exc_code;
    logic [1:0]  mmu_accessType;
    logic [31:0] mmu_pAddr = 32'd0;
    logic        mmu_io = 1'b0;
    logic [1:0]  mmu_exc = 2'd0;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we, ram_cs, io_cs;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .res(res), .req(req), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .busy(busy), .done(done),
        .rdata(rdata), .exc_valid(exc_valid), .exc_code(exc_code),
        .mmu_addrValid(mmu_addrValid), .mmu_accessType(mmu_accessType),
        .mmu_pAddr(mmu_pAddr), .mmu_io(mmu_io), .mmu_exc(mmu_exc),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we),
        .ram_cs(ram_cs), .io_cs(io_cs), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and follows it to done (or the cycle limit).
    // ack_dly = number of ACCESS cycles before ack; negative means never ack.
    task automatic run(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] wd, input logic [31:0] pa, input logic io,
                       input logic [1:0] me, input int ack_dly, input logic [31:0] brd,
                       input int limit, output int lat, output logic saw_cs,
                       output logic [31:0] c_addr, output logic [31:0] c_wdata,
                       output logic [3:0] c_be, output logic c_we, output logic c_ram,
                       output logic c_io, output logic [31:0] r_rdata,
                       output logic r_exc, output logic [2:0] r_code);
        int waits;
        req = 1'b1; req_write = wr; req_size = sz; req_signed = sg; req_wdata = wd;
        mmu_pAddr = pa; mmu_io = io; mmu_exc = me; bus_rdata = brd;
        saw_cs = 1'b0; c_addr = 0; c_wdata = 0; c_be = 0; c_we = 0; c_ram = 0; c_io = 0;
        r_rdata = 32'hBAD0_BAD0; r_exc = 1'bx; r_code = 3'bxxx;
        #1;
        chk("addrValid_on_req", {31'd0, mmu_addrValid}, 32'd1);
        chk("accessType_on_req", {30'd0, mmu_accessType}, {31'd0, wr});
        tick();
        req = 1'b0;
        lat = 1;
        waits = 0;
        while (!done && lat < limit) begin
            if (ram_cs || io_cs) begin
                if (!saw_cs) begin
                    c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be;
                    c_we = bus_we; c_ram = ram_cs; c_io = io_cs;
                end
                saw_cs = 1'b1;
                if (waits == ack_dly) bus_ack = 1'b1;
                waits++;
            end
            tick();
            bus_ack = 1'b0;
            lat++;
        end
        if (done) begin
            r_rdata = rdata; r_exc = exc_valid; r_code = exc_code;
        end
    endtask

    int          lat;
    logic        saw_cs, c_we, c_ram, c_io, r_exc;
    logic [31:0] c_addr, c_wdata, r_rdata;
    logic [3:0]  c_be;
    logic [2:0]  r_code;

    initial begin
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cs", {30'd0, ram_cs, io_cs}, 32'd0);
        chk("rst_bus", {bus_be, 3'd0, bus_we, 24'd0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_exc", {28'd0, exc_valid, exc_code}, 32'd0);
        res = 1'b1;
        tick();

        // Word load, zero wait states
        run(1'b0, 2'd2, 1'b0, 32'd0, 32'h0000_1000, 1'b0, 2'd0, 0, 32'hDEAD_BEEF, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("wl_lat", lat, 3);
        chk("wl_be", {28'd0, c_be}, 32'hF);
        chk("wl_addr", c_addr, 32'h0000_1000);
        chk("wl_cs", {30'd0, c_ram, c_io}, 32'd2);
        chk("wl_we", {31'd0, c_we}, 32'd0);
        chk("wl_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("wl_exc", {31'd0, r_exc}, 32'd0);
        tick();
        chk("wl_idle", {30'd0, busy, done}, 32'd0);

        // Signed and unsigned byte load from lane 3
        run(1'b0, 2'd0, 1'b1, 32'd0, 32'h0000_1003, 1'b0, 2'd0, 0, 32'h80FF_FFFF, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("sb_be", {28'd0, c_be}, 32'h8);
        chk("sb_addr", c_addr, 32'h0000_1000);
        chk("sb_rdata", r_rdata, 32'hFFFF_FF80);
        tick();
        run(1'b0, 2'd0, 1'b0, 32'd0, 32'h0000_1003, 1'b0, 2'd0, 0, 32'h80FF_FFFF, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("ub_rdata", r_rdata, 32'h0000_0080);
        tick();

        // Signed half load from upper lane
        run(1'b0, 2'd1, 1'b1, 32'd0, 32'h0000_2002, 1'b0, 2'd0, 1, 32'h9876_0000, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("sh_rdata", r_rdata, 32'hFFFF_9876);
        chk("sh_lat", lat, 4);
        tick();

        // Half store to IO with three wait states
        run(1'b1, 2'd1, 1'b0, 32'h1234_ABCD, 32'h0000_1002, 1'b1, 2'd0, 3, 32'hFFFF_FFFF, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("hs_cs", {30'd0, c_ram, c_io}, 32'd1);
        chk("hs_be", {28'd0, c_be}, 32'hC);
        chk("hs_wdata", c_wdata, 32'hABCD_ABCD);
        chk("hs_we", {31'd0, c_we}, 32'd1);
        chk("hs_lat", lat, 6);
        chk("hs_exc", {31'd0, r_exc}, 32'd0);
        chk("hs_rdata", r_rdata, 32'd0);
        chk("hs_cs_drop", {30'd0, ram_cs, io_cs}, 32'd0);
        tick();

        // TLB fault on a store
        run(1'b1, 2'd2, 1'b0, 32'h5555_5555, 32'h0000_3000, 1'b0, 2'd2, 0, 32'd0, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("tlbs_lat", lat, 2);
        chk("tlbs_code", {29'd0, r_code}, 32'd2);
        chk("tlbs_exc", {31'd0, r_exc}, 32'd1);
        chk("tlbs_nocs", {31'd0, saw_cs}, 32'd0);
        tick();

        // Misaligned word load and store
        run(1'b0, 2'd2, 1'b0, 32'd0, 32'h0000_1002, 1'b0, 2'd0, 0, 32'd0, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("adel_code", {29'd0, r_code}, 32'd4);
        chk("adel_nocs", {31'd0, saw_cs}, 32'd0);
        tick();
        run(1'b1, 2'd2, 1'b0, 32'd0, 32'h0000_1002, 1'b0, 2'd0, 0, 32'd0, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("ades_code", {29'd0, r_code}, 32'd5);
        chk("ades_exc", {31'd0, r_exc}, 32'd1);
        tick();

        // MMU exception outranks misalignment
        run(1'b0, 2'd2, 1'b0, 32'd0, 32'h0000_1001, 1'b0, 2'd1, 0, 32'd0, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("prio_code", {29'd0, r_code}, 32'd1);
        tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
        run(1'b0, 2'd2, 1'b0, 32'd0, 32'h0000_4000, 1'b0, 2'd0, -1, 32'd0, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("tmo_lat", lat, 6);
        chk("tmo_code", {29'd0, r_code}, 32'd6);
        chk("tmo_exc", {31'd0, r_exc}, 32'd1);
        chk("tmo_rdata", r_rdata, 32'd0);
        chk("tmo_cs_drop", {30'd0, ram_cs, io_cs}, 32'd0);
        tick();
`else
        run(1'b0, 2'd2, 1'b0, 32'd0, 32'h0000_4000, 1'b0, 2'd0, -1, 32'd0, 100,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("nomo_done", {31'd0, done}, 32'd0);
        chk("nomo_busy", {31'd0, busy}, 32'd1);
        chk("nomo_cs", {31'd0, ram_cs}, 32'd1);
        res = 1'b0;
        #2;
        res = 1'b1;
        tick();
`endif

        // Reset during ACCESS, with acks during and after reset
        req = 1'b1; req_write = 1'b0; req_size = 2'd2; mmu_pAddr = 32'h0000_2000;
        mmu_io = 1'b0; mmu_exc = 2'd0; bus_rdata = 32'h1111_2222;
        tick();
        req = 1'b0;
        tick();
        chk("mid_cs_before", {31'd0, ram_cs}, 32'd1);
        res = 1'b0;
        #1;
        chk("mid_cs_async", {30'd0, ram_cs, io_cs}, 32'd0);
        chk("mid_busy_async", {31'd0, busy}, 32'd0);
        chk("mid_be_async", {28'd0, bus_be}, 32'd0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        res = 1'b1;
        #1;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("late_ack_done", {31'd0, done}, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);
        tick();
        run(1'b0, 2'd2, 1'b0, 32'd0, 32'h0000_5004, 1'b0, 2'd0, 0, 32'hCAFE_F00D, 50,
            lat, saw_cs, c_addr, c_wdata, c_be, c_we, c_ram, c_io, r_rdata, r_exc, r_code);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", r_rdata, 32'hCAFE_F00D);
        chk("post_rst_addr", c_addr, 32'h0000_5004);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
